ps2_key_sequencer: RTL
======================

// Module: ps2_key_sequencer
// PURPOSE
//  Controller for the PS/2 byte receiver. Drives its rx_en and consumes rx_done_tick/rx_data.
//  Parses scan-code set 2 prefixes (E0 = extended, F0 = break) into whole key events.
//  Buffers events in a FIFO and presents them on a valid/ready port to the keyboard logic.
//  Flow control: throttles rx_en when the FIFO is full; flags protocol errors and overflow.
// PARAMETERS
//  FIFO_DEPTH   8       event FIFO entries; power of 2, >= 2
//  TIMEOUT_CYC  100000  max clk cycles between prefix and next byte (2 ms @ 50 MHz)
// PORTS
//  clk           in   1  system clock; all logic on posedge
//  reset         in   1  synchronous, active-high
//  en            in   1  sequencer enable; 0 holds rx_en low
//  rx_done_tick  in   1  one-cycle pulse from receiver: rx_data valid
//  rx_data       in   8  received byte
//  rx_en         out  1  receive enable to receiver
//  ev_valid      out  1  FIFO head event valid
//  ev_ready      in   1  consumer accepts head event
//  ev_code       out  8  key code of head event
//  ev_ext        out  1  head event carried E0 prefix
//  ev_brk        out  1  head event is a release (F0)
//  fifo_count    out  $clog2(FIFO_DEPTH)+1  occupied entries
//  overflow      out  1  sticky: event dropped, FIFO full
//  proto_err     out  1  sticky: illegal prefix sequence
//  timeout_err   out  1  sticky: prefix not followed in time
//  err_clr       in   1  one-cycle clear of all sticky flags
// BEHAVIOUR
//  Clock and reset:
//  - Single clock domain, clk. Reset is synchronous, active-high (reset); takes effect on the posedge.
//  - Reset values: parse=IDLE, FIFO empty, fifo_count=0, ev_valid=0, ev_* outputs=0,
//    rx_en=0, all sticky flags=0, timeout counter=0.
//  - Reset mid-frame: the FIFO and parse state are discarded. A byte the receiver completes
//    while rx_en=0 is still accepted if rx_done_tick arrives after reset deasserts.
//  rx_en:
//  - Registered: rx_en = en & (fifo_count < FIFO_DEPTH).
//  Parse FSM (acts only on rx_done_tick):
//  - IDLE: E0 -> EXT; F0 -> BRK; FA/AA/EE (ack/BAT/echo) dropped, no event;
//    any other byte b -> push {ext=0,brk=0,b}.
//  - EXT: F0 -> EXTBRK; E0 -> stay in EXT; other b -> push {1,0,b}, go to IDLE.
//  - BRK: E0 or F0 -> proto_err=1, then re-parse the byte as in IDLE; other b -> push {0,1,b}, go to IDLE.
//  - EXTBRK: E0 or F0 -> proto_err=1, then re-parse as in IDLE; other b -> push {1,1,b}, go to IDLE.
//  Event FIFO:
//  - First-word-fall-through. A push on the rx_done_tick cycle N is visible on ev_* with
//    ev_valid=1 in cycle N+1 when the FIFO was empty.
//  - Pop occurs when ev_valid & ev_ready. ev_* stay stable while ev_valid=1 and ev_ready=0.
//  - Push while full without a pop in the same cycle: the event is dropped, overflow=1,
//    FIFO contents are unchanged.
//  - Push and pop in the same cycle, including when full: both take effect, fifo_count unchanged.
//  - Read/write pointers wrap modulo FIFO_DEPTH.
//  Sticky flags:
//  - err_clr clears all sticky flags. A new error in the same cycle as err_clr wins (flag set).
//  - en=0 does not flush the FIFO or the parse state.
// CONFIGURATION
//  PS2_TIMEOUT_EN defined:
//  - A counter runs while parse state != IDLE and restarts on every rx_done_tick.
//  - On reaching TIMEOUT_CYC-1: parse -> IDLE, timeout_err=1, no event pushed.
//  PS2_TIMEOUT_EN undefined:
//  - No counter; the parse state waits indefinitely; timeout_err tied to 0.
// TESTING
//  1. Bytes 1C; 1C; F0,1C -> events {0,0,1C}, {0,0,1C}, {0,1,1C}; ev_valid 1 cycle after each final tick.
//  2. E0,75 then E0,F0,75 -> {1,0,75}, {1,1,75}. Byte FA -> no event, fifo_count unchanged.
//  3. ev_ready=0, push 9 codes with FIFO_DEPTH=8 -> rx_en=0 after 8th; 9th dropped, overflow=1;
//     drain 8 -> codes in push order, rx_en=1.
//  4. F0 then E0,74 -> proto_err=1 then event {1,0,74}. err_clr -> proto_err=0.
//  5. [PS2_TIMEOUT_EN, TIMEOUT_CYC=16] E0 then idle 20 cycles, then 1C -> timeout_err=1, event {0,0,1C}.
//  6. Reset asserted with 3 events queued and parse=EXT -> next cycle ev_valid=0, fifo_count=0, parse=IDLE.

Source files
------------

// File: rtl/ps2_key_sequencer_if.sv
// Key-event stream between the PS/2 key sequencer (master) and the keyboard logic (slave).
// Valid/ready handshake; the head event stays stable while valid is high and ready is low.
interface ps2_key_sequencer_if;
  logic       ev_valid;
  logic       ev_ready;
  logic [7:0] ev_code;
  logic       ev_ext;
  logic       ev_brk;

  modport master (output ev_valid, output ev_code, output ev_ext, output ev_brk, input ev_ready);
  modport slave  (input ev_valid, input ev_code, input ev_ext, input ev_brk, output ev_ready);
endinterface

// File: rtl/ps2_key_sequencer.sv
// PS/2 scan-code set 2 sequencer: folds E0/F0 prefixes into key events, buffers them in a FWFT FIFO.
// Optional prefix timeout watchdog is built when PS2_TIMEOUT_EN is defined.
module ps2_key_sequencer #(
  parameter int FIFO_DEPTH  = 8,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          en,
  input  logic                          rx_done_tick,
  input  logic [7:0]                    rx_data,
  output logic                          rx_en,
  ps2_key_sequencer_if.master           ev,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          proto_err,
  output logic                          timeout_err,
  input  logic                          err_clr
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) || (TIMEOUT_CYC < 2)) begin : g_bad_param
    $error("ps2_key_sequencer: FIFO_DEPTH must be a power of 2 >= 2 and TIMEOUT_CYC >= 2");
  end

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXT    = 2'd1,
    ST_BRK    = 2'd2,
    ST_EXTBRK = 2'd3
  } parse_t;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ev_t;

  parse_t          state_r;
  parse_t          state_nx_s;
  parse_t          idle_nx_s;
  logic            idle_push_s;
  logic            push_s;
  ev_t             push_ev_s;
  logic            proto_s;
  logic            tmo_hit_s;
  logic            tmo_err_s;

  ev_t             mem_r [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_r;
  logic [AW-1:0]   rd_ptr_r;
  logic [CW-1:0]   count_r;
  logic [CW-1:0]   count_nx_s;
  ev_t             head_r;
  ev_t             head_nx_s;
  logic            ev_valid_r;
  logic            full_s;
  logic            pop_s;
  logic            wr_s;
  logic            drop_s;

  logic            rx_en_r;
  logic            overflow_r;
  logic            proto_err_r;
  logic            timeout_err_r;

`ifdef PS2_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC);
  logic [TW-1:0] tmo_cnt_r;

  assign tmo_hit_s = (state_r != ST_IDLE) && (tmo_cnt_r == TW'(TIMEOUT_CYC - 1));
  assign tmo_err_s = tmo_hit_s & ~rx_done_tick;

  // Prefix watchdog: counts while a prefix is pending, restarts on every received byte.
  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_cnt_r <= '0;
    end else if (rx_done_tick || (state_r == ST_IDLE) || tmo_hit_s) begin
      tmo_cnt_r <= '0;
    end else begin
      tmo_cnt_r <= tmo_cnt_r + TW'(1);
    end
  end
`else
  assign tmo_hit_s = 1'b0;
  assign tmo_err_s = 1'b0;
`endif

  // How a byte is handled from IDLE; also reused when an illegal prefix forces a re-parse.
  always_comb begin
    idle_nx_s   = ST_IDLE;
    idle_push_s = 1'b0;
    case (rx_data)
      8'hE0:                idle_nx_s   = ST_EXT;
      8'hF0:                idle_nx_s   = ST_BRK;
      8'hFA, 8'hAA, 8'hEE:  idle_nx_s   = ST_IDLE;
      default:              idle_push_s = 1'b1;
    endcase
  end

  // Parse decode: next state, event to push and protocol error for the current byte.
  always_comb begin
    state_nx_s     = state_r;
    push_s         = 1'b0;
    push_ev_s.ext  = 1'b0;
    push_ev_s.brk  = 1'b0;
    push_ev_s.code = rx_data;
    proto_s        = 1'b0;
    if (rx_done_tick) begin
      case (state_r)
        ST_IDLE: begin
          state_nx_s = idle_nx_s;
          push_s     = idle_push_s;
        end
        ST_EXT: begin
          if (rx_data == 8'hF0) begin
            state_nx_s = ST_EXTBRK;
          end else if (rx_data == 8'hE0) begin
            state_nx_s = ST_EXT;
          end else begin
            state_nx_s    = ST_IDLE;
            push_s        = 1'b1;
            push_ev_s.ext = 1'b1;
          end
        end
        ST_BRK, ST_EXTBRK: begin
          if ((rx_data == 8'hE0) || (rx_data == 8'hF0)) begin
            proto_s    = 1'b1;
            state_nx_s = idle_nx_s;
            push_s     = idle_push_s;
          end else begin
            state_nx_s    = ST_IDLE;
            push_s        = 1'b1;
            push_ev_s.ext = (state_r == ST_EXTBRK);
            push_ev_s.brk = 1'b1;
          end
        end
        default: state_nx_s = ST_IDLE;
      endcase
    end else if (tmo_hit_s) begin
      state_nx_s = ST_IDLE;
    end else begin
      state_nx_s = state_r;
    end
  end

  // Parse state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  assign full_s     = (count_r == CW'(FIFO_DEPTH));
  assign pop_s      = ev_valid_r & ev.ev_ready;
  assign wr_s       = push_s & (~full_s | pop_s);
  assign drop_s     = push_s & full_s & ~pop_s;
  assign count_nx_s = count_r + CW'(wr_s) - CW'(pop_s);

  // Next head of the FIFO, so the event outputs can be registered while staying first-word-fall-through.
  always_comb begin
    head_nx_s = head_r;
    if (count_nx_s == '0) begin
      head_nx_s = '0;
    end else if (pop_s) begin
      if (count_r > CW'(1)) begin
        head_nx_s = mem_r[rd_ptr_r + AW'(1)];
      end else begin
        head_nx_s = push_ev_s;
      end
    end else if (count_r == '0) begin
      head_nx_s = push_ev_s;
    end else begin
      head_nx_s = head_r;
    end
  end

  // Event FIFO storage, pointers, occupancy and registered head.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      count_r    <= '0;
      head_r     <= '0;
      ev_valid_r <= 1'b0;
    end else begin
      if (wr_s) begin
        mem_r[wr_ptr_r] <= push_ev_s;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      count_r    <= count_nx_s;
      head_r     <= head_nx_s;
      ev_valid_r <= (count_nx_s != '0);
    end
  end

  // Receive enable follows the occupancy the FIFO will have after this edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_en_r <= 1'b0;
    end else begin
      rx_en_r <= en & (count_nx_s < CW'(FIFO_DEPTH));
    end
  end

  // Sticky error flags; a new error in the clear cycle keeps the flag set.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_r    <= 1'b0;
      proto_err_r   <= 1'b0;
      timeout_err_r <= 1'b0;
    end else if (err_clr) begin
      overflow_r    <= drop_s;
      proto_err_r   <= proto_s;
      timeout_err_r <= tmo_err_s;
    end else begin
      overflow_r    <= overflow_r | drop_s;
      proto_err_r   <= proto_err_r | proto_s;
      timeout_err_r <= timeout_err_r | tmo_err_s;
    end
  end

  assign rx_en       = rx_en_r;
  assign ev.ev_valid = ev_valid_r;
  assign ev.ev_code  = head_r.code;
  assign ev.ev_ext   = head_r.ext;
  assign ev.ev_brk   = head_r.brk;
  assign fifo_count  = count_r;
  assign overflow    = overflow_r;
  assign proto_err   = proto_err_r;
  assign timeout_err = timeout_err_r;

endmodule
